// File: rtl/mc_mips_controller.sv
// Multi-cycle MIPS control FSM: Moore decode of datapath selects and memory strobes.
// Optional MEM_WAIT_EN macro stretches FETCH/MEM_RD/MEM_WR until mem_ready is high.
module mc_mips_controller #(
    parameter int OPW = 6,
    parameter int SW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           mem_ready,
    output logic           IRWrite,
    output logic           RegDst,
    output logic           S1,
    output logic           S2,
    output logic           MemToReg,
    output logic           IorD,
    output logic           ALUSrcA,
    output logic           RegWrite,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     PCSrc,
    output logic [2:0]     ALUCtrl,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           illegal_op,
    output logic [SW-1:0]  o_dbg_state
);

    typedef enum logic [SW-1:0] {
        ST_FETCH, ST_DECODE, ST_R_EXE, ST_R_WB, ST_MEM_ADR, ST_MEM_RD, ST_MEM_WB,
        ST_MEM_WR, ST_BEQ, ST_J, ST_JAL, ST_JR, ST_I_EXE, ST_I_WB
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 'b000000;
    localparam logic [OPW-1:0] OP_LW    = 'b100011;
    localparam logic [OPW-1:0] OP_SW    = 'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 'b000100;
    localparam logic [OPW-1:0] OP_J     = 'b000010;
    localparam logic [OPW-1:0] OP_JAL   = 'b000011;
    localparam logic [OPW-1:0] OP_ADDI  = 'b001000;
    localparam logic [OPW-1:0] OP_SLTI  = 'b001010;
    localparam logic [OPW-1:0] FN_JR    = 'b001000;
    localparam logic [OPW-1:0] FN_ADD   = 'b100000;
    localparam logic [OPW-1:0] FN_SUB   = 'b100010;
    localparam logic [OPW-1:0] FN_AND   = 'b100100;
    localparam logic [OPW-1:0] FN_OR    = 'b100101;
    localparam logic [OPW-1:0] FN_SLT   = 'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_illegal;
    logic       w_set_illegal;
    logic [2:0] w_funct_alu;
    logic       w_funct_ok;
    logic       w_mem_go;

`ifdef MEM_WAIT_EN
    assign w_mem_go = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_funct_alu = ALU_ADD;
        w_funct_ok  = 1'b1;
        case (funct)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_SLT:  w_funct_alu = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // Everything stays 0 while rst is low so no strobe can leak out mid-reset.
    always_comb begin
        w_next_state  = ST_FETCH;
        w_set_illegal = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        S1            = 1'b0;
        S2            = 1'b0;
        MemToReg      = 1'b0;
        IorD          = 1'b0;
        ALUSrcA       = 1'b0;
        RegWrite      = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        ALUSrcB       = 2'b00;
        PCSrc         = 2'b00;
        ALUCtrl       = 3'b000;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        if (rst) begin
            case (r_state)
                ST_FETCH: begin
                    MemRead      = 1'b1;
                    IRWrite      = w_mem_go;
                    PCWrite      = w_mem_go;
                    ALUSrcB      = 2'b01;
                    ALUCtrl      = ALU_ADD;
                    w_next_state = w_mem_go ? ST_DECODE : ST_FETCH;
                end
                ST_DECODE: begin
                    ALUSrcB = 2'b11;
                    ALUCtrl = ALU_ADD;
                    case (opcode)
                        OP_RTYPE: begin
                            if (funct == FN_JR) begin
                                w_next_state = ST_JR;
                            end else if (w_funct_ok) begin
                                w_next_state = ST_R_EXE;
                            end else begin
                                w_set_illegal = 1'b1;
                            end
                        end
                        OP_LW, OP_SW:     w_next_state = ST_MEM_ADR;
                        OP_BEQ:           w_next_state = ST_BEQ;
                        OP_J:             w_next_state = ST_J;
                        OP_JAL:           w_next_state = ST_JAL;
                        OP_ADDI, OP_SLTI: w_next_state = ST_I_EXE;
                        default:          w_set_illegal = 1'b1;
                    endcase
                end
                ST_R_EXE: begin
                    ALUSrcA      = 1'b1;
                    ALUCtrl      = w_funct_alu;
                    w_next_state = ST_R_WB;
                end
                ST_R_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_MEM_ADR: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = 2'b10;
                    ALUCtrl      = ALU_ADD;
                    w_next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    IorD         = 1'b1;
                    MemRead      = 1'b1;
                    w_next_state = w_mem_go ? ST_MEM_WB : ST_MEM_RD;
                end
                ST_MEM_WB: begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_MEM_WR: begin
                    IorD         = 1'b1;
                    MemWrite     = 1'b1;
                    w_next_state = w_mem_go ? ST_FETCH : ST_MEM_WR;
                end
                ST_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUCtrl     = ALU_SUB;
                    PCSrc       = 2'b10;
                    PCWriteCond = 1'b1;
                end
                ST_J: begin
                    PCSrc   = 2'b01;
                    PCWrite = 1'b1;
                end
                ST_JAL: begin
                    PCSrc    = 2'b01;
                    PCWrite  = 1'b1;
                    S1       = 1'b1;
                    S2       = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_JR: begin
                    PCSrc   = 2'b11;
                    PCWrite = 1'b1;
                end
                ST_I_EXE: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = 2'b10;
                    ALUCtrl      = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                    w_next_state = ST_I_WB;
                end
                ST_I_WB: begin
                    RegWrite = 1'b1;
                end
                default: w_next_state = ST_FETCH;
            endcase
        end
    end

    assign illegal_op  = r_illegal;
    assign o_dbg_state = r_state;

endmodule

// File: doc/mc_mips_controller.md
Name: mc_mips_controller

Overview:
- Moore-style multi-cycle control FSM for the MIPS datapath.
- Sits directly upstream of the datapath. Consumes the IR opcode/funct fields and the datapath's zero-gated branch path, and drives every datapath select and write strobe plus the memory read/write strobes.
- One instruction is in flight at a time. Each state lasts one clock unless a memory wait stretches it.

Parameters:
- OPW, 6, opcode/funct field width
- SW, 4, state register width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- opcode  in  6  inst[31:26] from IR
- funct  in  6  inst[5:0] from IR
- mem_ready  in  1  memory access complete; honoured only with MEM_WAIT_EN
- IRWrite, RegDst, S1, S2, MemToReg, IorD, ALUSrcA, RegWrite, PCWrite, PCWriteCond  out  1 each  datapath controls
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext, 11 sign-ext<<2
- PCSrc  out  2  00 alu_out, 01 jump target, 10 alu_reg, 11 A
- ALUCtrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- MemRead, MemWrite  out  1 each  memory strobes
- illegal_op  out  1  sticky: unsupported opcode/funct decoded

Behaviour:
- While rst=0: state=FETCH, illegal_op=0, and all outputs are forced to 0, overriding the state decode.
- After rst releases, the first rising edge acts from FETCH.
- Outputs are combinational from state only (plus mem_ready gating under the macro). Any signal not listed for a state is 0.
- FETCH:
  - Outputs: IorD=0, MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUCtrl=ADD, PCSrc=00, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUCtrl=ADD (branch target into alu_reg).
  - Next state by opcode:
    - 000000 with funct 001000: JR.
    - 000000 with any other supported funct: R_EXE.
    - 100011 / 101011: MEM_ADR.
    - 000100: BEQ.
    - 000010: J.
    - 000011: JAL.
    - 001000 / 001010: I_EXE.
    - Anything else: set illegal_op, go to FETCH.
- R_EXE: ALUSrcA=1, ALUSrcB=00, ALUCtrl from funct. Funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; an unsupported funct is flagged illegal in DECODE. Next: R_WB.
- R_WB: RegDst=1, S1=0, MemToReg=0, S2=0, RegWrite=1. Next: FETCH.
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, ADD. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1, MemRead=1. Next: MEM_WB.
- MEM_WB: RegDst=0, MemToReg=1, RegWrite=1. Next: FETCH.
- MEM_WR: IorD=1, MemWrite=1. Next: FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=10, PCWriteCond=1. Next: FETCH.
- J: PCSrc=01, PCWrite=1. Next: FETCH.
- JAL: PCSrc=01, PCWrite=1, S1=1, S2=1, RegWrite=1 (r31 <= PC+4). Next: FETCH.
- JR: PCSrc=11, PCWrite=1. Next: FETCH.
- I_EXE: ALUSrcA=1, ALUSrcB=10; ALUCtrl ADD for addi, SLT for slti. Next: I_WB.
- I_WB: RegDst=0, MemToReg=0, RegWrite=1. Next: FETCH.
- Latency per instruction in cycles: R 4, lw 5, sw 4, addi/slti 4, beq/j/jal/jr 3, illegal 2.
- Unused state encodings go to FETCH on the next edge with no strobes asserted.
- illegal_op clears only on reset.
- Reset asserted mid-instruction: state returns to FETCH immediately, asynchronously. No partial write may occur after rst falls.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - In FETCH, MEM_RD and MEM_WR the state holds while mem_ready=0.
  - IRWrite and PCWrite in FETCH are asserted only when mem_ready=1. MemRead/MemWrite stay high through the wait.
  - The state advances on the edge where mem_ready=1.
- Undefined: mem_ready is ignored, and every memory access completes in one cycle.

Test Plan:
- Reset: hold rst=0 with a clk running → all outputs 0, illegal_op=0. Release → first cycle shows FETCH strobes (MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01).
- add (opcode 000000, funct 100000) → sequence FETCH, DECODE, R_EXE (ALUCtrl=010), R_WB (RegDst=1, RegWrite=1); next instruction fetched at cycle 5.
- lw (100011) then sw (101011) → lw: MEM_RD with IorD=1 and MemRead=1, then RegWrite with MemToReg=1 at cycle 5. sw: MemWrite=1 at cycle 4, no RegWrite.
- beq (000100) → cycle 3 shows PCWriteCond=1, PCSrc=10, ALUCtrl=110, PCWrite=0.
- jal (000011) then jr (funct 001000) → jal cycle 3: S1=1, S2=1, RegWrite=1, PCSrc=01. jr cycle 3: PCSrc=11, PCWrite=1.
- opcode 111111 → illegal_op rises after DECODE and stays 1 through the following add. With MEM_WAIT_EN and mem_ready held 0 for 3 cycles in FETCH → IRWrite=0 for those cycles, state held, advance on the cycle mem_ready=1.
